// File: rtl/arm_fetch_pkg.sv
// ---------------------------------------------------------------------------
// arm_fetch_pkg
//  Shared definitions for the instruction fetch stage: instruction field
//  slice positions, the fetch FSM state type and the PC arithmetic constants.
// ---------------------------------------------------------------------------
package arm_fetch_pkg;

   // Field slices of a 32-bit ARM instruction word
   localparam int COND_HI  = 31;
   localparam int COND_LO  = 28;
   localparam int OP_HI    = 27;
   localparam int OP_LO    = 26;
   localparam int FUNCT_HI = 25;
   localparam int FUNCT_LO = 20;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 12;

   // Sequential fetch step and the R15 read offset (fetch address + 8)
   localparam int PC_STEP     = 4;
   localparam int PC_READ_OFS = 8;

   // IDLE: may issue a request; REQ: live request awaiting IAck;
   // DROP: request was overtaken by a redirect, its response is discarded
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//  Small synchronous prefetch FIFO with a combinational head read.
//  Ports:
//   CLK, Reset        clock, asynchronous active-high reset
//   push, push_data   write an entry (accepted when not full or when popping)
//   pop               remove the head entry (ignored when empty)
//   flush             empty the FIFO; wins over a same-cycle push/pop
//   head_data         current head entry (content undefined when empty)
//   empty, count      occupancy status (registered)
// ---------------------------------------------------------------------------
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                   CLK,
   input  logic                   Reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [WIDTH-1:0]       head_data,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         do_push  = 1'b0;
         do_pop   = 1'b0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; occupancy alone decides validity
   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign head_data = mem_q[rd_ptr_q];
   assign empty     = (count_q == '0);
   assign count     = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//  ARM fetch stage: owns the PC, issues word reads over a req/ack handshake,
//  buffers returned words with their PC+8 in a prefetch FIFO and presents the
//  head instruction with its decoded fields. PCSrc redirects and flushes.
//  Ports:
//   CLK, Reset                 clock, asynchronous active-high reset
//   IReq, IAddr, IAck, IRData  instruction memory handshake (one outstanding)
//   Instr, InstrValid, InstrReady  head instruction and consume handshake
//   Cond, Op, Funct, Rd        fields of Instr (0 when empty)
//   PCPlus8                    fetch address of head + 8 (0 when empty)
//   PCSrc, BranchTarget        redirect request and target (bits [1:0] ignored)
//   FetchCount, FlushCount     performance counters
//  Build option: FETCH_PERF_CNT_EN enables the counters; without it both
//  counter outputs are tied to 0.
// ---------------------------------------------------------------------------
module instr_fetch_unit
   import arm_fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              CLK,
   input  logic              Reset,
   output logic              IReq,
   output logic [ADDR_W-1:0] IAddr,
   input  logic              IAck,
   input  logic [31:0]       IRData,
   output logic [31:0]       Instr,
   output logic              InstrValid,
   input  logic              InstrReady,
   output logic [3:0]        Cond,
   output logic [1:0]        Op,
   output logic [5:0]        Funct,
   output logic [3:0]        Rd,
   output logic [ADDR_W-1:0] PCPlus8,
   input  logic              PCSrc,
   input  logic [ADDR_W-1:0] BranchTarget,
   output logic [31:0]       FetchCount,
   output logic [31:0]       FlushCount
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = 32 + ADDR_W;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] iaddr_q, iaddr_d;
   logic [ADDR_W-1:0] redirect_pc;
   logic              push, pop;
   logic [EW-1:0]     head_data;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;

   assign redirect_pc = BranchTarget & ~ADDR_W'(3);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      iaddr_d = iaddr_q;
      push    = 1'b0;
      unique case (state_q)
         IDLE: begin
            // fifo_count is registered: a pop this cycle frees space next cycle
            if (!PCSrc && (fifo_count < CW'(DEPTH))) begin
               iaddr_d = pc_q;
               pc_d    = pc_q + ADDR_W'(PC_STEP);
               state_d = REQ;
            end
         end
         REQ: begin
            if (IAck) begin
               push    = !PCSrc;
               state_d = IDLE;
            end else if (PCSrc) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (IAck) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (PCSrc) pc_d = redirect_pc;
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         iaddr_q <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         iaddr_q <= iaddr_d;
      end
   end

   assign IReq  = (state_q != IDLE);
   assign IAddr = iaddr_q;
   assign pop   = InstrValid && InstrReady;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .CLK       (CLK),
      .Reset     (Reset),
      .push      (push),
      .push_data ({IRData, iaddr_q + ADDR_W'(PC_READ_OFS)}),
      .pop       (pop),
      .flush     (PCSrc),
      .head_data (head_data),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign InstrValid = !fifo_empty;
   assign Instr      = InstrValid ? head_data[EW-1:ADDR_W] : '0;
   assign PCPlus8    = InstrValid ? head_data[ADDR_W-1:0]  : '0;
   assign Cond       = Instr[COND_HI:COND_LO];
   assign Op         = Instr[OP_HI:OP_LO];
   assign Funct      = Instr[FUNCT_HI:FUNCT_LO];
   assign Rd         = Instr[RD_HI:RD_LO];

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      // a flush cancels a same-cycle pop, so it is not a delivery
      fetch_cnt_d = fetch_cnt_q + 32'(pop && !PCSrc);
      flush_cnt_d = flush_cnt_q + 32'(PCSrc && (InstrValid || IReq));
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign FetchCount = fetch_cnt_q;
   assign FlushCount = flush_cnt_q;
`else
   assign FetchCount = '0;
   assign FlushCount = '0;
`endif

endmodule
